console_mem_cycle: RTL

- Parametrised console examine/deposit engine for the processor front panel.
- Turns EXAMINE, EXAMINE NEXT, DEPOSIT and DEPOSIT NEXT key presses into complete membus read or write cycles, loading MA, AR and MB along the way.
- Adds what a bare key sequencer lacks:
  - configurable address, data and select widths;
  - a programmable key-settle delay;
  - a non-existent-memory (NXM) timeout;
  - a busy interlock;
  - a repeat mode for scope loops.

---
 rtl/console_mem_cycle.sv | 284 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/console_mem_cycle.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : console_mem_cycle                                          |
// | Description : Front-panel examine/deposit engine. Turns EXAMINE,         |
// |               EXAMINE NEXT, DEPOSIT and DEPOSIT NEXT key presses into    |
// |               complete membus read/write cycles, loading MA, AR and MB,  |
// |               with key-settle delay, NXM timeout, busy interlock and an  |
// |               auto-repeat mode for scope loops.                          |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
// Ports:
//   clk, reset (async, active low)
//   key_ex/key_ex_nxt/key_dep/key_dep_nxt : console key levels
//   sw_repeat : auto-repeat last operation   sw_fmc : fast-memory select
//   mas / datasw : address / data switches
//   ma / ar / mb : console registers         busy / nxm : status
//   membus_* : memory bus request, address, data and handshake lines
module console_mem_cycle #(
    parameter int AW   = 18,
    parameter int MAW  = 15,
    parameter int SW   = 4,
    parameter int DW   = 36,
    parameter int KDLY = 20,
    parameter int TMO  = 1024,
    parameter int RPT  = 50000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          key_ex,
    input  logic          key_ex_nxt,
    input  logic          key_dep,
    input  logic          key_dep_nxt,
    input  logic          sw_repeat,
    input  logic          sw_fmc,
    input  logic [AW-1:0] mas,
    input  logic [DW-1:0] datasw,
    output logic [AW-1:0] ma,
    output logic [DW-1:0] ar,
    output logic [DW-1:0] mb,
    output logic          busy,
    output logic          nxm,
    output logic          membus_rq_cyc,
    output logic          membus_rd_rq,
    output logic          membus_wr_rq,
    output logic          membus_wr_rs,
    output logic [MAW-1:0] membus_ma,
    output logic [SW-1:0] membus_sel,
    output logic          membus_fmc_select,
    output logic [DW-1:0] membus_mb_out,
    input  logic          membus_addr_ack,
    input  logic          membus_rd_rs,
    input  logic [DW-1:0] membus_mb_in
);

    // One shared counter serves the key delays, the NXM timeout and the
    // repeat spacing, so it is sized for the largest of the three.
    localparam int CMAX = (KDLY > TMO) ? ((KDLY > RPT) ? KDLY : RPT)
                                       : ((TMO > RPT) ? TMO : RPT);
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] C_KDLY = CW'(KDLY);
    localparam logic [CW-1:0] C_TMO1 = CW'(TMO - 1);
    localparam logic [CW-1:0] C_RPT1 = CW'(RPT - 1);

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        KT0  = 4'd1,
        KT1  = 4'd2,
        RQ   = 4'd3,
        RDW  = 4'd4,
        WRS  = 4'd5,
        DONE = 4'd6,
        RPTW = 4'd7
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] ma_q, ma_d;
    logic [DW-1:0] ar_q, ar_d;
    logic [DW-1:0] mb_q, mb_d;
    logic          busy_q, busy_d;
    logic          nxm_q, nxm_d;
    logic          op_wr_q, op_wr_d;     // latched "last key": write vs read
    logic          op_nxt_q, op_nxt_d;   // latched "last key": next variant
    logic          key_or_q, key_or_d;
    logic          rd_rs_q, rd_rs_d;

    logic          key_or;
    logic          key_edge;
    logic          rd_rs_edge;
    logic          in_cycle;

    assign key_or     = key_ex | key_ex_nxt | key_dep | key_dep_nxt;
    assign key_edge   = key_or & ~key_or_q;
    assign rd_rs_edge = membus_rd_rs & ~rd_rs_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ma_q     <= '0;
            ar_q     <= '0;
            mb_q     <= '0;
            busy_q   <= 1'b0;
            nxm_q    <= 1'b0;
            op_wr_q  <= 1'b0;
            op_nxt_q <= 1'b0;
            key_or_q <= 1'b0;
            rd_rs_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ma_q     <= ma_d;
            ar_q     <= ar_d;
            mb_q     <= mb_d;
            busy_q   <= busy_d;
            nxm_q    <= nxm_d;
            op_wr_q  <= op_wr_d;
            op_nxt_q <= op_nxt_d;
            key_or_q <= key_or_d;
            rd_rs_q  <= rd_rs_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ma_d     = ma_q;
        ar_d     = ar_q;
        mb_d     = mb_q;
        busy_d   = busy_q;
        nxm_d    = nxm_q;
        op_wr_d  = op_wr_q;
        op_nxt_d = op_nxt_q;
        // Key and rd_rs history track every cycle, so a key held through a
        // busy period can never produce a late, queued edge.
        key_or_d = key_or;
        rd_rs_d  = membus_rd_rs;

        unique case (state_q)
            IDLE: begin
                if (key_edge) begin
                    state_d  = KT0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    nxm_d    = 1'b0;
                    // Priority dep_nxt > dep > ex_nxt > ex.
                    op_wr_d  = key_dep_nxt | key_dep;
                    op_nxt_d = key_dep_nxt | (~key_dep & key_ex_nxt);
                end
            end

            KT0: begin
                if (cnt_q == '0) begin
                    ma_d = op_nxt_q ? (ma_q + 1'b1) : '0;
                    if (op_wr_q) begin
                        ar_d = '0;
                    end else begin
                        mb_d = '0;
                    end
                end
                if (cnt_q == C_KDLY) begin
                    state_d = KT1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            KT1: begin
                if (cnt_q == '0) begin
                    if (!op_nxt_q) begin
                        ma_d = ma_q | mas;
                    end
                    if (op_wr_q) begin
                        ar_d = ar_q | datasw;
                    end
                end
                if (cnt_q == C_KDLY) begin
                    // ar_d rather than ar_q so a zero delay still sees the
                    // freshly ORed data switches.
                    if (op_wr_q) begin
                        mb_d = ar_d;
                    end
                    state_d = RQ;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            RQ: begin
                if (membus_addr_ack) begin
                    state_d = op_wr_q ? WRS : RDW;
                    cnt_d   = '0;
                end else if (cnt_q == C_TMO1) begin
                    nxm_d   = 1'b1;
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            RDW: begin
                // Read data is a wired-OR bus: accumulate every cycle,
                // including the one where the restart edge arrives.
                mb_d = mb_q | membus_mb_in;
                if (rd_rs_edge) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else if (cnt_q == C_TMO1) begin
                    nxm_d   = 1'b1;
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            WRS: begin
                // Two drive cycles: restart pulse + data, then data only.
                if (cnt_q == '0) begin
                    cnt_d = {{(CW-1){1'b0}}, 1'b1};
                end else begin
                    state_d = DONE;
                    cnt_d   = '0;
                end
            end

            DONE: begin
                cnt_d = '0;
                if (sw_repeat) begin
                    state_d = RPTW;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end

            RPTW: begin
                if (cnt_q == C_RPT1) begin
                    cnt_d = '0;
                    if (sw_repeat) begin
                        state_d = KT0;
                        nxm_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Bus outputs decode directly from registered state so that an
    // asynchronous reset clears them immediately.
    assign in_cycle = (state_q == RQ) || (state_q == RDW) || (state_q == WRS);

    assign ma   = ma_q;
    assign ar   = ar_q;
    assign mb   = mb_q;
    assign busy = busy_q;
    assign nxm  = nxm_q;

    assign membus_rq_cyc     = (state_q == RQ);
    assign membus_rd_rq      = ~op_wr_q & ((state_q == RQ) || (state_q == RDW));
    assign membus_wr_rq      =  op_wr_q & ((state_q == RQ) || (state_q == WRS));
    assign membus_wr_rs      = (state_q == WRS) && (cnt_q == '0);
    assign membus_ma         = in_cycle ? ma_q[MAW-1:0] : '0;
    assign membus_sel        = in_cycle ? ma_q[AW-1 -: SW] : '0;
    assign membus_fmc_select = in_cycle & sw_fmc;
    assign membus_mb_out     = (state_q == WRS) ? mb_q : '0;

endmodule
`default_nettype wire
